hdmi_timing_gen: RTL

// - Raster timing generator and pixel-fetch sequencer for the ADV7513 RGB 4:4:4 output path; default 640x480@60 on 25 MHz CLK_PX.
// - Sits between the I2C config sequencer (consumes its ready) and the image ROM.
// - Drives ROM addresses, aligns DE/HS/VS with returned ROM data, and drives the HDMI pins.

---
 rtl/hdmi_timing_gen_pkg.sv | 32 +++
 rtl/hdmi_timing_gen_sig_delay.sv | 27 ++
 rtl/hdmi_timing_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hdmi_timing_gen_pkg.sv
// Shared raster constants (640x480@60 defaults), FSM encoding and pixel type
// for the HDMI timing generator and its helpers.
package hdmi_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOT    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOT    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
   localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef logic [23:0] pixel_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hdmi_timing_gen_sig_delay.sv
// Fixed-depth flop delay line (DEPTH >= 1), async reset to RST_VAL.
// Latency DEPTH clocks; always advances, no backpressure.
module sig_delay #(
   parameter int           W       = 1,
   parameter int           DEPTH   = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         CLK_PX,
   input  logic         RST_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q [DEPTH];

   always_ff @(posedge CLK_PX or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= RST_VAL;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/hdmi_timing_gen.sv
// Raster counters, start/stop FSM and row-major ROM addressing; DE/HS/VS/FS delayed to meet ROM data.
// Pins lag the counters by RD_LAT+1 clocks; ready only gates frame starts, a started frame always completes.
module hdmi_timing_gen
   import hdmi_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int RD_LAT   = 2,
   parameter int ADDR_W   = 19
) (
   input  logic              CLK_PX,
   input  logic              RST_n,
   input  logic              ready,
   input  logic [23:0]       PX_IN,
   output logic [ADDR_W-1:0] PX_ADDR,
   output logic              HDMI_CLK,
   output logic              HDMI_DE,
   output logic              HDMI_HS,
   output logic              HDMI_VS,
   output logic [23:0]       HDMI_PX,
   output logic              FRAME_START
);

   localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int HW       = cnt_w(H_TOT);
   localparam int VW       = cnt_w(V_TOT);

   state_t            state_q;
   logic [HW-1:0]     h_q;
   logic [VW-1:0]     v_q;
   logic [ADDR_W-1:0] addr_q;

   logic       run, h_last, v_last;
   logic       act_raw, hs_raw, vs_raw, fs_raw;
   logic [3:0] raw_vec, dly_vec;
   logic       act_dly, hs_dly, vs_dly, fs_dly;
   pixel_t     px_d, px_q;
   logic       de_q, hs_q, vs_q, fs_q;

   assign run     = (state_q == RUN);
   assign h_last  = (int'(h_q) == H_TOT - 1);
   assign v_last  = (int'(v_q) == V_TOT - 1);
   assign act_raw = run && (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
   assign hs_raw  = run && (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
   assign vs_raw  = run && (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
   assign fs_raw  = run && (h_q == '0) && (v_q == '0);

   // Address walks forward one per visible pixel, so row-major order needs no multiply.
   always_ff @(posedge CLK_PX or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         addr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               h_q    <= '0;
               v_q    <= '0;
               addr_q <= '0;
               if (ready) state_q <= RUN;
            end
            RUN: begin
               if (act_raw) addr_q <= addr_q + ADDR_W'(1);
               if (!h_last) begin
                  h_q <= h_q + HW'(1);
               end else begin
                  h_q <= '0;
                  if (!v_last) begin
                     v_q <= v_q + VW'(1);
                  end else begin
                     v_q    <= '0;
                     addr_q <= '0;
                     if (!ready) state_q <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign raw_vec = {fs_raw, vs_raw, hs_raw, act_raw};

   sig_delay #(
      .W       (4),
      .DEPTH   (RD_LAT),
      .RST_VAL (4'b0000)
   ) u_align (
      .CLK_PX (CLK_PX),
      .RST_n  (RST_n),
      .d_i    (raw_vec),
      .q_o    (dly_vec)
   );

   assign {fs_dly, vs_dly, hs_dly, act_dly} = dly_vec;
   assign px_d = act_dly ? PX_IN : '0;

   always_ff @(posedge CLK_PX or negedge RST_n) begin
      if (!RST_n) begin
         de_q <= 1'b0;
         hs_q <= ~SYNC_POL;
         vs_q <= ~SYNC_POL;
         fs_q <= 1'b0;
         px_q <= '0;
      end else begin
         de_q <= act_dly;
         hs_q <= SYNC_POL ? hs_dly : ~hs_dly;
         vs_q <= SYNC_POL ? vs_dly : ~vs_dly;
         fs_q <= fs_dly;
         px_q <= px_d;
      end
   end

   assign PX_ADDR     = addr_q;
   assign HDMI_CLK    = ~CLK_PX;
   assign HDMI_DE     = de_q;
   assign HDMI_HS     = hs_q;
   assign HDMI_VS     = vs_q;
   assign HDMI_PX     = px_q;
   assign FRAME_START = fs_q;

endmodule
